cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - icache line-refill / dcache single-word arbiter onto one downstream bus
// Optional ARB_RR_EN: round-robin grant on simultaneous requests; undefined gives data fixed priority.
module cache_bus_arbiter #(
  parameter int LINE_WORDS = 16,
  parameter int BEAT_CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  input  logic [3:0]               i_burst,
  output logic                     i_addr_ok,
  output logic                     i_data_ok,
  output logic [32*LINE_WORDS-1:0] i_rdata,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [3:0]               d_wstrb,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_addr_ok,
  output logic                     d_data_ok,
  output logic [31:0]              d_rdata,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [3:0]               m_wstrb,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_wdata,
  output logic [3:0]               m_burst,
  input  logic                     m_addr_ok,
  input  logic                     m_rvalid,
  input  logic [31:0]              m_rdata,
  input  logic                     m_rlast,
  input  logic                     m_wdone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [BEAT_CNT_W-1:0] LP_LAST_BEAT = BEAT_CNT_W'(LINE_WORDS - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  // r_owner doubles as the last-grant record used by round-robin arbitration
  logic                    r_owner;
  logic                    r_m_wr;
  logic [3:0]              r_m_wstrb;
  logic [31:0]             r_m_addr;
  logic [31:0]             r_m_wdata;
  logic [3:0]              r_m_burst;
  logic [32*LINE_WORDS-1:0] r_i_rdata;
  logic [31:0]             r_d_rdata;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic                    r_beat_full;

  logic                    w_any_req;
  logic                    w_grant_data;
  logic                    w_txn_done;

  assign w_any_req = i_req | d_req;

`ifdef ARB_RR_EN
  assign w_grant_data = d_req & (~i_req | (r_owner == OWNER_INST));
`else
  assign w_grant_data = d_req;
`endif

  assign w_txn_done = ((r_owner == OWNER_DATA) && r_m_wr) ? m_wdone : (m_rvalid & m_rlast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)  w_next_state = S_ADDR;
      S_ADDR:  if (m_addr_ok)  w_next_state = S_DATA;
      S_DATA:  if (w_txn_done) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    m_req     = 1'b0;
    i_addr_ok = 1'b0;
    d_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    case (r_state)
      S_ADDR: begin
        m_req     = 1'b1;
        i_addr_ok = m_addr_ok && (r_owner == OWNER_INST);
        d_addr_ok = m_addr_ok && (r_owner == OWNER_DATA);
      end
      S_RESP: begin
        i_data_ok = (r_owner == OWNER_INST);
        d_data_ok = (r_owner == OWNER_DATA);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWNER_DATA;
      r_m_wr      <= 1'b0;
      r_m_wstrb   <= 4'b0000;
      r_m_addr    <= 32'h0;
      r_m_wdata   <= 32'h0;
      r_m_burst   <= 4'b0000;
      r_i_rdata   <= '0;
      r_d_rdata   <= 32'h0;
      r_beat_cnt  <= '0;
      r_beat_full <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_data;
            if (w_grant_data) begin
              r_m_wr    <= d_wr;
              r_m_wstrb <= d_wstrb;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              r_m_burst <= 4'b0000;
            end else begin
              r_m_wr    <= 1'b0;
              r_m_wstrb <= 4'b0000;
              r_m_addr  <= i_addr;
              r_m_wdata <= 32'h0;
              r_m_burst <= i_burst;
            end
          end
        end
        S_DATA: begin
          if (m_rvalid) begin
            if (r_owner == OWNER_INST) begin
              // r_beat_full marks the line complete so surplus beats are dropped
              if (!r_beat_full) begin
                for (int w = 0; w < LINE_WORDS; w++) begin
                  if (r_beat_cnt == BEAT_CNT_W'(w)) begin
                    r_i_rdata[32*(LINE_WORDS-w)-1 -: 32] <= m_rdata;
                  end
                end
                if (r_beat_cnt == LP_LAST_BEAT) begin
                  r_beat_full <= 1'b1;
                end else begin
                  r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                end
              end
            end else if (!r_m_wr) begin
              r_d_rdata <= m_rdata;
            end
          end
        end
        S_RESP: begin
          r_beat_cnt  <= '0;
          r_beat_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_wr    = r_m_wr;
  assign m_wstrb = r_m_wstrb;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_burst = r_m_burst;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - randomized bench for cache_bus_arbiter with a transaction-level reference model
module tb_cache_bus_arbiter;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [31:0]   i_addr = 32'h0;
  logic [3:0]    i_burst = 4'hF;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic [511:0]  i_rdata;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [3:0]    d_wstrb = 4'h0;
  logic [31:0]   d_addr = 32'h0;
  logic [31:0]   d_wdata = 32'h0;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [31:0]   d_rdata;
  logic          m_req;
  logic          m_wr;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_burst;
  logic          m_addr_ok = 1'b0;
  logic          m_rvalid = 1'b0;
  logic [31:0]   m_rdata = 32'h0;
  logic          m_rlast = 1'b0;
  logic          m_wdone = 1'b0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.LINE_WORDS(LW), .BEAT_CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_burst(m_burst), .m_addr_ok(m_addr_ok), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_wdone(m_wdone)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl_line [LW];
  logic [31:0] mdl_drd = 32'h0;
  bit          mdl_last_data = 1'b1;
  logic        e_m_req = 1'b0, e_iao = 1'b0, e_dao = 1'b0, e_ido = 1'b0, e_ddo = 1'b0;
  logic        e_wr = 1'b0;
  logic [3:0]  e_wstrb = 4'h0, e_burst = 4'h0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  bit          chk_en = 1'b0;

  bit          pend_line = 1'b0;
  int          pend_idx = 0;
  logic [31:0] pend_word = 32'h0;
  bit          pend_d = 1'b0;
  logic [31:0] pend_dword = 32'h0;

  int          beat_mode = 0;
  logic [31:0] beat_fixed = 32'h0;

  int          ido_count = 0;
  int          iao_count = 0;
  bit          dut_grants[$];
  logic [31:0] seen_addr = 32'h0;
  logic [3:0]  seen_burst = 4'h0;
  logic [3:0]  seen_wstrb = 4'h0;

  function automatic logic [511:0] model_line();
    logic [511:0] v;
    for (int k = 0; k < LW; k++) v[(LW-1-k)*32 +: 32] = mdl_line[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_data_ok) ido_count++;
    if (i_addr_ok) begin iao_count++; dut_grants.push_back(1'b0); end
    if (d_addr_ok) dut_grants.push_back(1'b1);
    if (m_req) begin seen_addr = m_addr; seen_burst = m_burst; seen_wstrb = m_wstrb; end
    if (chk_en) begin
      check("m_req", 512'(m_req), 512'(e_m_req));
      check("i_addr_ok", 512'(i_addr_ok), 512'(e_iao));
      check("d_addr_ok", 512'(d_addr_ok), 512'(e_dao));
      check("i_data_ok", 512'(i_data_ok), 512'(e_ido));
      check("d_data_ok", 512'(d_data_ok), 512'(e_ddo));
      check("i_rdata", i_rdata, model_line());
      check("d_rdata", 512'(d_rdata), 512'(mdl_drd));
      if (e_m_req) begin
        check("m_wr", 512'(m_wr), 512'(e_wr));
        check("m_wstrb", 512'(m_wstrb), 512'(e_wstrb));
        check("m_addr", 512'(m_addr), 512'(e_addr));
        check("m_wdata", 512'(m_wdata), 512'(e_wdata));
        check("m_burst", 512'(m_burst), 512'(e_burst));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_line) begin mdl_line[pend_idx] = pend_word; pend_line = 1'b0; end
    if (pend_d) begin mdl_drd = pend_dword; pend_d = 1'b0; end
    m_addr_ok = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_wdone = 1'b0; m_rdata = 32'h0;
    e_m_req = 1'b0; e_iao = 1'b0; e_dao = 1'b0; e_ido = 1'b0; e_ddo = 1'b0;
  endtask

  // Response traffic the arbiter must ignore outside the data phase
  task automatic noise();
    m_rvalid = 1'($urandom);
    m_rlast  = 1'($urandom);
    m_wdone  = 1'($urandom);
    m_rdata  = $urandom;
  endtask

  task automatic release_req(input bit w);
    if (w) d_req = 1'b0;
    else   i_req = 1'b0;
  endtask

  task automatic mid_reset();
    tick();
    rst = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < LW; k++) mdl_line[k] = 32'h0;
    mdl_drd = 32'h0;
    mdl_last_data = 1'b1;
    #1;
    check("midrst_m_req", 512'(m_req), 512'(0));
    check("midrst_i_data_ok", 512'(i_data_ok), 512'(0));
    check("midrst_i_rdata", i_rdata, 512'(0));
    check("midrst_m_addr", 512'(m_addr), 512'(0));
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic serve(input bit w, input int nbeats, input int abort_at, input int fixed_gap);
    int dly;
    int gap;
    int nb;
    bit first;
    if (w) begin
      e_wr = d_wr; e_wstrb = d_wstrb; e_addr = d_addr; e_wdata = d_wdata; e_burst = 4'h0;
    end else begin
      e_wr = 1'b0; e_wstrb = 4'h0; e_addr = i_addr; e_wdata = 32'h0; e_burst = i_burst;
    end
    dly = int'($urandom_range(0, 3));
    for (int c = 0; c <= dly; c++) begin
      tick();
      noise();
      e_m_req = 1'b1;
      if (c == dly) begin m_addr_ok = 1'b1; e_iao = !w; e_dao = w; end
    end
    first = 1'b1;
    if (w && e_wr) begin
      gap = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 4));
      for (int c = 0; c <= gap; c++) begin
        tick();
        if (first) begin release_req(w); first = 1'b0; end
        if (c == gap) m_wdone = 1'b1;
      end
    end else begin
      nb = w ? 1 : nbeats;
      for (int k = 0; k < nb; k++) begin
        gap = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 2));
        for (int c = 0; c <= gap; c++) begin
          tick();
          if (first) begin release_req(w); first = 1'b0; end
          if (c == gap) begin
            m_rvalid = 1'b1;
            m_rlast  = (k == nb - 1);
            m_rdata  = (beat_mode == 1) ? 32'(k) : (beat_mode == 2) ? beat_fixed : $urandom;
            if (w) begin
              pend_d = 1'b1; pend_dword = m_rdata;
            end else if (k < LW) begin
              pend_line = 1'b1; pend_idx = k; pend_word = m_rdata;
            end
          end
        end
        if (k == abort_at) begin
          mid_reset();
          return;
        end
      end
    end
    tick();
    e_ido = !w;
    e_ddo = w;
  endtask

  task automatic run_pair(input bit ri, input bit rd, input int nbeats, input int fixed_gap);
    bit w;
    tick();
    noise();
    i_req = ri;
    d_req = rd;
`ifdef ARB_RR_EN
    w = (ri && rd) ? !mdl_last_data : rd;
`else
    w = rd;
`endif
    mdl_last_data = w;
    serve(w, nbeats, -1, fixed_gap);
    if (ri && rd) begin
      tick();
      noise();
      mdl_last_data = !w;
      serve(!w, nbeats, -1, fixed_gap);
    end
  endtask

  task automatic rand_fields();
    i_addr  = $urandom & 32'hFFFF_FFC0;
    i_burst = 4'hF;
    d_wr    = 1'($urandom);
    d_wstrb = 4'($urandom);
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
  endtask

  initial begin
    int ido0;
    int iao0;
    int r;
    logic [3:0] g;
    logic [3:0] exp_g;
    for (int k = 0; k < LW; k++) mdl_line[k] = 32'h0;
    #1 rst = 1'b0;
    #1;
    check("rst_m_req", 512'(m_req), 512'(0));
    check("rst_i_addr_ok", 512'(i_addr_ok), 512'(0));
    check("rst_d_addr_ok", 512'(d_addr_ok), 512'(0));
    check("rst_i_data_ok", 512'(i_data_ok), 512'(0));
    check("rst_d_data_ok", 512'(d_data_ok), 512'(0));
    check("rst_i_rdata", i_rdata, 512'(0));
    check("rst_d_rdata", 512'(d_rdata), 512'(0));
    check("rst_m_fields", 512'({m_wr, m_wstrb, m_addr, m_wdata, m_burst}), 512'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Inst refill alone with beats 0..F
    beat_mode = 1;
    i_addr = 32'hBFC0_0040; i_burst = 4'hF;
    ido0 = ido_count;
    run_pair(1'b1, 1'b0, 16, -1);
    tick();
    check("req019_m_addr", 512'(seen_addr), 512'(32'hBFC0_0040));
    check("req019_top_word", 512'(i_rdata[511:480]), 512'(0));
    check("req019_low_word", 512'(i_rdata[31:0]), 512'(32'hF));
    check("req019_data_ok_count", 512'(ido_count - ido0), 512'(1));

    // Data read
    beat_mode = 2; beat_fixed = 32'h1234_5678;
    d_wr = 1'b0; d_addr = 32'h8000_1000; d_wstrb = 4'hF; d_wdata = 32'h0;
    run_pair(1'b0, 1'b1, 1, -1);
    tick();
    check("req020_m_burst", 512'(seen_burst), 512'(0));
    check("req020_m_addr", 512'(seen_addr), 512'(32'h8000_1000));
    check("req020_d_rdata", 512'(d_rdata), 512'(32'h1234_5678));

    // Data write, response after a fixed delay
    d_wr = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h8000_2004; d_wdata = 32'hCAFE_F00D;
    ido0 = ido_count; iao0 = iao_count;
    run_pair(1'b0, 1'b1, 1, 3);
    tick();
    check("req021_m_wstrb", 512'(seen_wstrb), 512'(4'b0011));
    check("req021_i_pulses", 512'((ido_count - ido0) + (iao_count - iao0)), 512'(0));
    check("req021_d_rdata_held", 512'(d_rdata), 512'(32'h1234_5678));

    // Reset after beat 7 of a refill
    beat_mode = 0;
    rand_fields();
    tick();
    i_req = 1'b1;
    mdl_last_data = 1'b0;
    serve(1'b0, 16, 7, -1);
    ido0 = ido_count;
    repeat (6) tick();
    check("req023_no_data_ok", 512'(ido_count - ido0), 512'(0));

    // Simultaneous requests twice
    dut_grants.delete();
    rand_fields();
    run_pair(1'b1, 1'b1, 16, -1);
    rand_fields();
    run_pair(1'b1, 1'b1, 16, -1);
    tick();
    check("req022_grant_count", 512'(dut_grants.size()), 512'(4));
    g = 4'h0;
    for (int i = 0; i < 4 && i < dut_grants.size(); i++) g = {g[2:0], dut_grants[i]};
`ifdef ARB_RR_EN
    exp_g = 4'b0101;
`else
    exp_g = 4'b1010;
`endif
    check("req022_grant_order", 512'(g), 512'(exp_g));

    // 18 beats: surplus beats discarded
    beat_mode = 1;
    rand_fields();
    ido0 = ido_count;
    run_pair(1'b1, 1'b0, 18, -1);
    tick();
    check("req024_low_word", 512'(i_rdata[31:0]), 512'(32'hF));
    check("req024_top_word", 512'(i_rdata[511:480]), 512'(0));
    check("req024_data_ok_count", 512'(ido_count - ido0), 512'(1));

    // Randomized traffic
    beat_mode = 0;
    for (int n = 0; n < 60; n++) begin
      rand_fields();
      r = int'($urandom_range(1, 3));
      run_pair(r[0], r[1], ($urandom_range(0, 1) == 0) ? 16 : 18, -1);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        noise();
      end
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
